// File: rtl/spi_param_loader.sv
// spi_param_loader
// SPI mode-0 slave front end that fills the 125x8 network parameter memory.
// A frame is a command byte {w, a[6:0]} followed by data bytes; each data
// byte is written to the memory port with an auto-incrementing address that
// wraps at DEPTH-1. Every completed byte is echoed back on MISO during the
// following byte so the host can check the link.

module spi_param_loader #(
    parameter int DEPTH = 125,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sclk,
    input  logic          cs_n,
    input  logic          mosi,
    output logic          miso,
    output logic [AW-1:0] addr,
    output logic [7:0]    data_out,
    output logic          write_enable,
    output logic          busy,
    output logic          frame_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CMD    = 2'd1;
    localparam logic [1:0] S_DATA   = 2'd2;
    localparam logic [1:0] S_IGNORE = 2'd3;

    localparam logic [7:0]    DEPTH_LIMIT = 8'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);

    // Synchroniser stages for the three asynchronous SPI inputs.
    // cs_n resets to the inactive (high) level so busy starts low.
    logic r_sclkMeta;
    logic r_sclkSync;
    logic r_csnMeta;
    logic r_csnSync;
    logic r_mosiMeta;
    logic r_mosiSync;

    // Previous synchronised samples and registered edge pulses.
    logic r_sclkPrev;
    logic r_csnPrev;
    logic r_mosiDly;
    logic r_sclkRiseDet;
    logic r_sclkFallDet;
    logic r_csnRiseDet;
    logic r_csnFallDet;

    // Post-reset arming: a frame already running when reset is released
    // must not be picked up half way through.
    logic [1:0] r_settle;
    logic       r_armed;

    // Frame state and datapath.
    logic [1:0]    r_state;
    logic [2:0]    r_bitCnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_misoShift;
    logic          r_misoBit;
    logic [AW-1:0] r_addrCnt;
    logic [AW-1:0] r_addrOut;
    logic [7:0]    r_dataOut;
    logic          r_we;
    logic          r_err;

    logic [7:0] w_nextShift;
    logic [2:0] w_bitCntNext;
    logic       w_byteDone;
    logic       w_cmdValid;
    logic       w_partial;

    // The byte being completed is the shift register with the current
    // (delay-matched) MOSI bit appended at the LSB end.
    assign w_nextShift  = {r_shift[6:0], r_mosiDly};
    assign w_bitCntNext = r_sclkRiseDet ? (r_bitCnt + 3'd1) : r_bitCnt;
    assign w_byteDone   = r_sclkRiseDet && (r_bitCnt == 3'd7);
    assign w_cmdValid   = w_nextShift[7] && ({1'b0, w_nextShift[6:0]} < DEPTH_LIMIT);
    assign w_partial    = (w_bitCntNext != 3'd0);

    assign miso         = r_misoBit & ~r_csnSync;
    assign addr         = r_addrOut;
    assign data_out     = r_dataOut;
    assign write_enable = r_we;
    assign busy         = ~r_csnSync;
    assign frame_err    = r_err;

    // Two-flop synchronisers bringing sclk, cs_n and mosi into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclkMeta <= 1'b0;
            r_sclkSync <= 1'b0;
            r_csnMeta  <= 1'b1;
            r_csnSync  <= 1'b1;
            r_mosiMeta <= 1'b0;
            r_mosiSync <= 1'b0;
        end else begin
            r_sclkMeta <= sclk;
            r_sclkSync <= r_sclkMeta;
            r_csnMeta  <= cs_n;
            r_csnSync  <= r_csnMeta;
            r_mosiMeta <= mosi;
            r_mosiSync <= r_mosiMeta;
        end
    end

    // Registered edge detection; MOSI is delayed one stage so it lines up
    // with the SCLK edge pulse it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclkPrev    <= 1'b0;
            r_csnPrev     <= 1'b1;
            r_mosiDly     <= 1'b0;
            r_sclkRiseDet <= 1'b0;
            r_sclkFallDet <= 1'b0;
            r_csnRiseDet  <= 1'b0;
            r_csnFallDet  <= 1'b0;
        end else begin
            r_sclkPrev    <= r_sclkSync;
            r_csnPrev     <= r_csnSync;
            r_mosiDly     <= r_mosiSync;
            r_sclkRiseDet <= r_sclkSync & ~r_sclkPrev;
            r_sclkFallDet <= ~r_sclkSync & r_sclkPrev;
            r_csnRiseDet  <= r_csnSync & ~r_csnPrev;
            r_csnFallDet  <= ~r_csnSync & r_csnPrev;
        end
    end

    // Arm frame detection only once cs_n has been seen high with the
    // synchronisers holding real samples rather than their reset values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle <= 2'd0;
            r_armed  <= 1'b0;
        end else begin
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
            if ((r_settle == 2'd3) && r_csnSync) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Frame FSM: command decode, byte assembly, memory write strobe,
    // MISO echo register and protocol error reporting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bitCnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_misoShift <= 8'h00;
            r_misoBit   <= 1'b0;
            r_addrCnt   <= '0;
            r_addrOut   <= '0;
            r_dataOut   <= 8'h00;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_we  <= 1'b0;
            r_err <= 1'b0;

            if (r_sclkFallDet) begin
                r_misoBit   <= r_misoShift[7];
                r_misoShift <= {r_misoShift[6:0], 1'b0};
            end

            case (r_state)
                S_IDLE: begin
                    if (r_csnFallDet && r_armed) begin
                        r_state     <= S_CMD;
                        r_bitCnt    <= 3'd0;
                        r_shift     <= 8'h00;
                        r_misoShift <= 8'h00;
                        r_misoBit   <= 1'b0;
                    end
                end

                S_CMD: begin
                    if (r_sclkRiseDet) begin
                        r_shift  <= w_nextShift;
                        r_bitCnt <= w_bitCntNext;
                    end
                    if (w_byteDone) begin
                        r_misoShift <= w_nextShift;
                        if (w_cmdValid) begin
                            r_addrCnt <= AW'(w_nextShift[6:0]);
                            r_state   <= S_DATA;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_IGNORE;
                        end
                    end
                    if (r_csnRiseDet) begin
                        r_state <= S_IDLE;
                        if (w_partial) begin
                            r_err <= 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (r_sclkRiseDet) begin
                        r_shift  <= w_nextShift;
                        r_bitCnt <= w_bitCntNext;
                    end
                    if (w_byteDone) begin
                        r_misoShift <= w_nextShift;
                        r_dataOut   <= w_nextShift;
                        r_addrOut   <= r_addrCnt;
                        r_we        <= 1'b1;
                        r_addrCnt   <= (r_addrCnt == LAST_ADDR) ? '0 : (r_addrCnt + AW'(1));
                    end
                    if (r_csnRiseDet) begin
                        r_state <= S_IDLE;
                        if (w_partial) begin
                            r_err <= 1'b1;
                        end
                    end
                end

                S_IGNORE: begin
                    if (r_csnRiseDet) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_param_loader.sv
// tb_spi_param_loader
// Directed and randomized SPI frames against spi_param_loader. Expected
// writes, error pulses and MISO echoes come from a frame-level model built
// from the command byte, the data bytes and any trailing partial bits.

module tb_spi_param_loader;

    localparam int DEPTH = 125;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          sclk;
    logic          cs_n;
    logic          mosi;
    logic          miso;
    logic [AW-1:0] addr;
    logic [7:0]    data_out;
    logic          write_enable;
    logic          busy;
    logic          frame_err;

    int testCount = 0;
    int failCount = 0;
    int errCount  = 0;
    int errBase   = 0;
    int wrBase    = 0;
    int partialBits = 0;

    logic [AW-1:0] wrAddrQ[$];
    logic [7:0]    wrDataQ[$];
    logic [7:0]    frameQ[$];
    logic [7:0]    rxQ[$];

    spi_param_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .addr         (addr),
        .data_out     (data_out),
        .write_enable (write_enable),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    // Record every write strobe and every frame_err cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (write_enable) begin
                wrAddrQ.push_back(addr);
                wrDataQ.push_back(data_out);
            end
            if (frame_err) begin
                errCount++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Shift nBits of val out MSB first, capturing MISO just before each rising edge.
    task automatic sendBits(input logic [7:0] val, input int nBits, input int halfNs, output logic [7:0] rx);
        logic [7:0] v;
        v  = val;
        rx = 8'h00;
        for (int i = 0; i < nBits; i++) begin
            mosi = v[7];
            v    = {v[6:0], 1'b0};
            #(halfNs);
            rx   = {rx[6:0], miso};
            sclk = 1'b1;
            #(halfNs);
            sclk = 1'b0;
        end
    endtask

    // Drive one frame from frameQ (plus partialBits trailing bits) at a random phase.
    task automatic applyStimulus(input int halfClk);
        int         halfNs;
        logic [7:0] rx;
        halfNs  = halfClk * 10;
        wrBase  = wrAddrQ.size();
        errBase = errCount;
        rxQ.delete();
        @(posedge clk);
        #($urandom_range(1, 4));
        cs_n = 1'b0;
        #60;
        checkOutput("busy_in_frame", 32'(busy), 32'd1);
        foreach (frameQ[i]) begin
            sendBits(frameQ[i], 8, halfNs, rx);
            rxQ.push_back(rx);
        end
        if (partialBits > 0) begin
            sendBits(8'($urandom), partialBits, halfNs, rx);
        end
        #(halfNs);
        cs_n = 1'b1;
        #150;
        checkOutput("busy_after_frame", 32'(busy), 32'd0);
        checkOutput("miso_idle", 32'(miso), 32'd0);
    endtask

    // Frame-level model: what the memory port, frame_err and MISO should show.
    task automatic checkFrame(input bit checkMiso);
        logic [7:0] cmd;
        bit         valid;
        int         a;
        int         expErr;
        int         nW;
        int         expA[$];
        int         expD[$];
        valid  = 1'b0;
        expErr = 0;
        if (frameQ.size() > 0) begin
            cmd   = frameQ[0];
            valid = cmd[7] && (int'(cmd[6:0]) < DEPTH);
            if (valid) begin
                a = int'(cmd[6:0]);
                for (int i = 1; i < frameQ.size(); i++) begin
                    expA.push_back(a);
                    expD.push_back(int'(frameQ[i]));
                    a = (a + 1) % DEPTH;
                end
            end else begin
                expErr = 1;
            end
        end
        if ((partialBits > 0) && (frameQ.size() == 0 || valid)) begin
            expErr = expErr + 1;
        end
        nW = wrAddrQ.size() - wrBase;
        checkOutput("write_count", 32'(nW), 32'(expA.size()));
        for (int i = 0; i < expA.size() && i < nW; i++) begin
            checkOutput("write_addr", 32'(wrAddrQ[wrBase + i]), 32'(expA[i]));
            checkOutput("write_data", 32'(wrDataQ[wrBase + i]), 32'(expD[i]));
        end
        checkOutput("frame_err_count", 32'(errCount - errBase), 32'(expErr));
        if (checkMiso && valid) begin
            for (int k = 0; k < rxQ.size(); k++) begin
                checkOutput("miso_echo", 32'(rxQ[k]), (k == 0) ? 32'd0 : 32'(frameQ[k - 1]));
            end
        end
    endtask

    initial begin
        logic [7:0] rx;
        int         half;
        int         nData;

        reset = 1'b1;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        #23;
        checkOutput("reset_miso", 32'(miso), 32'd0);
        checkOutput("reset_addr", 32'(addr), 32'd0);
        checkOutput("reset_data", 32'(data_out), 32'd0);
        checkOutput("reset_we", 32'(write_enable), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        #200;

        // Single write.
        frameQ = '{8'h85, 8'h3C};
        partialBits = 0;
        applyStimulus(8);
        checkFrame(1'b1);

        // Burst wrapping from 124 back to 0.
        frameQ = '{8'hFB, 8'h11, 8'h22, 8'h33};
        applyStimulus(8);
        checkFrame(1'b1);

        // Read command and out-of-range address are both rejected.
        frameQ = '{8'h05, 8'hAA};
        applyStimulus(8);
        checkFrame(1'b0);
        frameQ = '{8'hFD, 8'hAA};
        applyStimulus(8);
        checkFrame(1'b0);

        // Partial trailing byte, then a normal frame.
        frameQ = '{8'h80, 8'h55};
        partialBits = 5;
        applyStimulus(8);
        checkFrame(1'b1);
        frameQ = '{8'h83, 8'h66, 8'h77};
        partialBits = 0;
        applyStimulus(8);
        checkFrame(1'b1);

        // Reset in the middle of the second data byte.
        @(posedge clk);
        #3;
        cs_n = 1'b0;
        #60;
        sendBits(8'h82, 8, 80, rx);
        sendBits(8'h44, 8, 80, rx);
        sendBits(8'hC3, 3, 80, rx);
        #40;
        reset = 1'b1;
        #1;
        checkOutput("midrst_miso", 32'(miso), 32'd0);
        checkOutput("midrst_addr", 32'(addr), 32'd0);
        checkOutput("midrst_data", 32'(data_out), 32'd0);
        checkOutput("midrst_we", 32'(write_enable), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_err", 32'(frame_err), 32'd0);
        wrBase  = wrAddrQ.size();
        errBase = errCount;
        #39;
        reset = 1'b0;
        #40;
        sendBits(8'hFF, 5, 80, rx);
        sendBits(8'h99, 8, 80, rx);
        checkOutput("post_rst_miso", 32'(rx), 32'd0);
        #80;
        cs_n = 1'b1;
        #150;
        checkOutput("post_rst_writes", 32'(wrAddrQ.size() - wrBase), 32'd0);
        checkOutput("post_rst_errs", 32'(errCount - errBase), 32'd0);
        frameQ = '{8'h90, 8'h7E};
        applyStimulus(8);
        checkFrame(1'b1);

        // Random frames, alternating the 4x clock ratio with slower SCLK.
        for (int f = 0; f < 24; f++) begin
            half = ((f % 2) == 0) ? 2 : int'($urandom_range(6, 10));
            frameQ.delete();
            if ($urandom_range(0, 3) != 0) begin
                frameQ.push_back({1'b1, 7'($urandom_range(0, DEPTH - 1))});
            end else begin
                frameQ.push_back(8'($urandom));
            end
            nData = int'($urandom_range(0, 5));
            for (int i = 0; i < nData; i++) begin
                frameQ.push_back(8'($urandom));
            end
            partialBits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            applyStimulus(half);
            checkFrame(half >= 6);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/spi_param_loader.md
# spi_param_loader

SPI-slave front end that fills the network parameter memory from an external host. Deserialises SPI mode-0 frames (command byte, then data bytes), and drives a byte-wide write port (address, data, one-cycle write strobe) into the 125×8 parameter memory with auto-incrementing address. It also echoes received bytes on MISO for link checking. It is the writer side of the memory's `addr`/`data_in`/`write_enable` port.

## Interface
- `DEPTH`, 125: number of memory bytes; valid addresses are 0..DEPTH-1.
- `AW`, 7: address width.
- `clk`  in  1  system clock; must be ≥ 4× SCLK frequency.
- `reset`  in  1  asynchronous, active-high reset.
- `sclk`  in  1  SPI clock, asynchronous to `clk`, idle low.
- `cs_n`  in  1  SPI chip select, active low, asynchronous.
- `mosi`  in  1  SPI data in, MSB first.
- `miso`  out  1  SPI data out, MSB first.
- `addr`  out  AW  memory write address.
- `data_out`  out  8  memory write data.
- `write_enable`  out  1  one-`clk` write strobe.
- `busy`  out  1  high while a frame is active (synchronised `cs_n` low).
- `frame_err`  out  1  one-`clk` pulse on a protocol error.

## Operation
- `sclk`, `cs_n`, `mosi` each pass through a 2-FF synchroniser. Edges are detected from the synchronised `sclk` and the previous sample.
- Data is sampled on the synchronised SCLK rising edge, shifted MSB first into an 8-bit shift register with a 3-bit bit counter. Rising edges are ignored while synchronised `cs_n` is high.
- FSM states:
  - IDLE → CMD on synchronised `cs_n` falling. Clears the bit counter and shift register; loads the MISO register with 0x00.
  - CMD: on the 8th bit, examine the command byte `{w, a[6:0]}`.
    - If `w=1` and `a<DEPTH`: load the address counter with `a` and go to DATA.
    - Otherwise: pulse `frame_err` and go to IGNORE.
  - DATA: on each completed 8th bit, present the byte on `data_out`, the current address on `addr`, and pulse `write_enable`. Then increment the address counter, wrapping DEPTH-1 → 0.
  - IGNORE: discard all bits until `cs_n` rises.
  - Any state → IDLE on synchronised `cs_n` rising. If the bit counter ≠ 0 in CMD or DATA, pulse `frame_err`; the partial byte is never written.
- MISO:
  - Each completed byte (command or data) is loaded into the MISO shift register.
  - On each synchronised SCLK falling edge the MSB is shifted out, so byte n+1 of a frame returns byte n; the first byte returns 0x00.
  - `miso` is driven 0 while `cs_n` is high.
- `addr` and `data_out` hold their last written values between strobes.

## Timing
- Reset values: `miso`=0, `addr`=0, `data_out`=0x00, `write_enable`=0, `busy`=0, `frame_err`=0, FSM=IDLE, counters=0.
- Reset takes effect immediately and asynchronously, including mid-frame. After release the block waits for a fresh `cs_n` falling edge; a frame already in progress at release is ignored until `cs_n` rises (treated as IGNORE).
- Latency:
  - Synchroniser: 2 cycles. Edge detect: 1 cycle.
  - `write_enable` is registered and asserted in the cycle after the detect cycle: 4 `clk` after the physical 8th SCLK rising edge.
  - `addr`/`data_out` are valid in the same cycle as the strobe.
- `write_enable` is high for exactly 1 cycle per byte. Minimum spacing is 8 SCLK periods (≥32 `clk`).
- `busy` follows synchronised `cs_n` (2-cycle lag).
- Simultaneous 8th-bit rising edge and `cs_n` rise in the same synchronised cycle: the byte completes and is written, then the FSM goes to IDLE with no `frame_err`.
- Address increment after the last byte of a frame is harmless; every frame reloads the address from its command byte.

## Test plan
- Single write: frame 0x85, 0x3C → one `write_enable` pulse with `addr`=5, `data_out`=0x3C; `frame_err` never pulses; `busy` high for the frame duration.
- Burst with wrap: frame 0xFB (a=123), then 0x11, 0x22, 0x33 → three writes at addr 123, 124, 0 with data 0x11, 0x22, 0x33; MISO returns 0x00, 0xFB, 0x11, 0x22 across the four bytes.
- Invalid command: frame 0x05, 0xAA → no write, one `frame_err` after the command byte. Frame 0xFD (a=125), 0xAA → no write, one `frame_err`.
- Partial byte: frame 0x80, 0x55, then 5 bits, then `cs_n` high → exactly one write (addr 0, 0x55), then one `frame_err`; the next full frame writes normally.
- Reset mid-frame: assert `reset` during the 2nd data byte → all outputs return to their reset values immediately; no spurious `write_enable`; after release and a new frame 0x90, 0x7E → write addr 16, data 0x7E.
- Clock ratio stress: `clk` = 4× SCLK with random SCLK phase → all bytes are written correctly and no extra strobes occur.
